// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: assembles big-endian 16-bit instructions from two
// byte reads, presents them under valid/ready and owns the PC (advance, redirect, fault).
module fetch_sequencer #(
  parameter int                ADDR_W    = 16,
  parameter int                MEM_DEPTH = 128,
  parameter logic [ADDR_W-1:0] RESET_PC  = 16'h0000
) (
  input  logic              Clock,
  input  logic              ResetN,
  input  logic              Enable,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRdEn,
  input  logic [7:0]        MemRdData,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] RedirectPC,
  output logic [15:0]       Instruction,
  output logic [ADDR_W-1:0] InstrPC,
  output logic              InstrValid,
  input  logic              InstrReady,
  output logic              AddrFault,
  output logic [15:0]       FetchCount
);

  localparam logic [ADDR_W-1:0] MAX_PC = ADDR_W'(MEM_DEPTH - 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HI,
    ST_LO,
    ST_DONE,
    ST_WAIT,
    ST_FAULT
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [7:0]          hi_q, hi_d;
  logic [15:0]         instr_q, instr_d;
  logic [ADDR_W-1:0]   instrPc_q, instrPc_d;
  logic                valid_q, valid_d;
  logic [15:0]         count_q, count_d;
  logic                legal;

  assign legal = (pc_q[0] == 1'b0) && (pc_q <= MAX_PC);

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      hi_q      <= '0;
      instr_q   <= '0;
      instrPc_q <= '0;
      valid_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      hi_q      <= hi_d;
      instr_q   <= instr_d;
      instrPc_q <= instrPc_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
    end
  end

  // Memory data arrives one cycle after the strobe, so the high byte is taken in LO
  // and the low byte in DONE.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    hi_d      = hi_q;
    instr_d   = instr_q;
    instrPc_d = instrPc_q;
    valid_d   = valid_q;
    count_d   = count_q;
    case (state_q)
      ST_IDLE: begin
        if (Enable) state_d = legal ? ST_HI : ST_FAULT;
      end
      ST_HI: state_d = ST_LO;
      ST_LO: begin
        hi_d    = MemRdData;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        instr_d   = {hi_q, MemRdData};
        instrPc_d = pc_q;
        valid_d   = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (InstrReady) begin
          valid_d = 1'b0;
          pc_d    = pc_q + ADDR_W'(2);
          count_d = count_q + 16'd1;
          state_d = ST_IDLE;
        end
      end
      ST_FAULT: ;
      default: state_d = ST_IDLE;
    endcase
    // A concurrent accept still counts; only the PC choice is overridden.
    if (Redirect) begin
      pc_d    = RedirectPC;
      valid_d = 1'b0;
      hi_d    = '0;
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    MemRdEn = (state_q == ST_HI) || (state_q == ST_LO);
    MemAddr = (state_q == ST_LO) ? pc_q + ADDR_W'(1) : pc_q;
  end

  assign Instruction = instr_q;
  assign InstrPC     = instrPc_q;
  assign InstrValid  = valid_q;
  assign AddrFault   = (state_q == ST_FAULT);
  assign FetchCount  = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a byte memory model feeds the DUT and a
// scoreboard queue holds {PC, instruction} expected at each presented fetch.
module tb_fetch_sequencer;

  logic        Clock = 1'b0;
  logic        ResetN;
  logic        Enable;
  logic [15:0] MemAddr;
  logic        MemRdEn;
  logic [7:0]  MemRdData;
  logic        Redirect;
  logic [15:0] RedirectPC;
  logic [15:0] Instruction;
  logic [15:0] InstrPC;
  logic        InstrValid;
  logic        InstrReady;
  logic        AddrFault;
  logic [15:0] FetchCount;

  logic [7:0]  mem [0:127];
  logic [31:0] sb [$];
  logic [31:0] exp;
  int          checks = 0;
  int          errors = 0;

  fetch_sequencer #(.ADDR_W(16), .MEM_DEPTH(128), .RESET_PC(16'h0000)) dut (
    .Clock(Clock), .ResetN(ResetN), .Enable(Enable),
    .MemAddr(MemAddr), .MemRdEn(MemRdEn), .MemRdData(MemRdData),
    .Redirect(Redirect), .RedirectPC(RedirectPC),
    .Instruction(Instruction), .InstrPC(InstrPC), .InstrValid(InstrValid),
    .InstrReady(InstrReady), .AddrFault(AddrFault), .FetchCount(FetchCount)
  );

  always #5 Clock = ~Clock;

  // Synchronous byte memory with one cycle of read latency.
  always @(posedge Clock) begin
    if (MemRdEn) MemRdData <= (MemAddr < 16'd128) ? mem[MemAddr[6:0]] : 8'h00;
  end

  task automatic pushExpect(input logic [15:0] pc);
    logic [6:0] a;
    a = pc[6:0];
    sb.push_back({pc, mem[a], mem[a + 7'd1]});
  endtask

  task automatic waitValid(input string name);
    int n;
    n = 0;
    while (InstrValid !== 1'b1 && n < 20) begin
      @(negedge Clock);
      n++;
    end
    checks++;
    if (InstrValid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_timeout InstrValid got %b want 1", name, InstrValid);
    end
  endtask

  task automatic test_reset;
    ResetN = 1'b0; Enable = 1'b0; Redirect = 1'b0; RedirectPC = '0; InstrReady = 1'b0;
    repeat (2) @(negedge Clock);
    checks++;
    if ({InstrValid, AddrFault, MemRdEn} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_flags got %b want 000", {InstrValid, AddrFault, MemRdEn});
    end
    checks++;
    if ({FetchCount, Instruction, InstrPC, MemAddr} !== 64'h0) begin
      errors++;
      $display("[TB] FAIL reset_values got %h want 0", {FetchCount, Instruction, InstrPC, MemAddr});
    end
    ResetN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      checks++;
      if (MemRdEn !== 1'b0) begin
        errors++;
        $display("[TB] FAIL idle_no_enable MemRdEn got %b want 0", MemRdEn);
      end
    end
  endtask

  task automatic test_first_fetch;
    Enable = 1'b1; InstrReady = 1'b1;
    pushExpect(16'h0000);
    @(negedge Clock);
    checks++;
    if ({MemRdEn, MemAddr} !== {1'b1, 16'h0000}) begin
      errors++;
      $display("[TB] FAIL first_hi_addr got %b/%h want 1/0000", MemRdEn, MemAddr);
    end
    @(negedge Clock);
    checks++;
    if ({MemRdEn, MemAddr} !== {1'b1, 16'h0001}) begin
      errors++;
      $display("[TB] FAIL first_lo_addr got %b/%h want 1/0001", MemRdEn, MemAddr);
    end
    @(negedge Clock);
    checks++;
    if (InstrValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL first_early_valid got %b want 0", InstrValid);
    end
    @(negedge Clock);
    exp = sb.pop_front();
    checks++;
    if ({InstrValid, InstrPC, Instruction} !== {1'b1, exp}) begin
      errors++;
      $display("[TB] FAIL first_instr got %b/%h/%h want 1/%h/%h", InstrValid, InstrPC, Instruction, exp[31:16], exp[15:0]);
    end
    @(negedge Clock);
    checks++;
    if ({InstrValid, FetchCount} !== {1'b0, 16'd1}) begin
      errors++;
      $display("[TB] FAIL first_accept got %b/%0d want 0/1", InstrValid, FetchCount);
    end
    @(negedge Clock);
    checks++;
    if ({MemRdEn, MemAddr} !== {1'b1, 16'h0002}) begin
      errors++;
      $display("[TB] FAIL next_fetch_addr got %b/%h want 1/0002", MemRdEn, MemAddr);
    end
  endtask

  task automatic test_stall;
    InstrReady = 1'b0;
    pushExpect(16'h0002);
    waitValid("stall");
    exp = sb.pop_front();
    checks++;
    if ({InstrPC, Instruction} !== exp) begin
      errors++;
      $display("[TB] FAIL stall_instr got %h/%h want %h/%h", InstrPC, Instruction, exp[31:16], exp[15:0]);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      checks++;
      if ({InstrValid, MemRdEn, FetchCount, InstrPC, Instruction} !== {1'b1, 1'b0, 16'd1, exp}) begin
        errors++;
        $display("[TB] FAIL stall_hold cyc %0d got %b/%b/%0d/%h/%h want 1/0/1/%h/%h", i, InstrValid, MemRdEn, FetchCount, InstrPC, Instruction, exp[31:16], exp[15:0]);
      end
    end
    InstrReady = 1'b1;
    @(negedge Clock);
    checks++;
    if ({InstrValid, FetchCount} !== {1'b0, 16'd2}) begin
      errors++;
      $display("[TB] FAIL stall_accept got %b/%0d want 0/2", InstrValid, FetchCount);
    end
    @(negedge Clock);
    checks++;
    if ({MemRdEn, MemAddr} !== {1'b1, 16'h0004}) begin
      errors++;
      $display("[TB] FAIL stall_next_addr got %b/%h want 1/0004", MemRdEn, MemAddr);
    end
  endtask

  task automatic test_redirect_lo;
    @(negedge Clock);
    checks++;
    if ({MemRdEn, MemAddr} !== {1'b1, 16'h0005}) begin
      errors++;
      $display("[TB] FAIL redir_in_lo got %b/%h want 1/0005", MemRdEn, MemAddr);
    end
    Redirect = 1'b1; RedirectPC = 16'h0040;
    @(negedge Clock);
    Redirect = 1'b0;
    checks++;
    if ({InstrValid, MemRdEn, MemAddr} !== {2'b00, 16'h0040}) begin
      errors++;
      $display("[TB] FAIL redir_idle got %b/%b/%h want 0/0/0040", InstrValid, MemRdEn, MemAddr);
    end
    pushExpect(16'h0040);
    @(negedge Clock);
    checks++;
    if ({MemRdEn, MemAddr} !== {1'b1, 16'h0040}) begin
      errors++;
      $display("[TB] FAIL redir_read got %b/%h want 1/0040", MemRdEn, MemAddr);
    end
    waitValid("redirect");
    exp = sb.pop_front();
    checks++;
    if ({InstrPC, Instruction} !== exp) begin
      errors++;
      $display("[TB] FAIL redir_instr got %h/%h want %h/%h", InstrPC, Instruction, exp[31:16], exp[15:0]);
    end
    @(negedge Clock);
    checks++;
    if (FetchCount !== 16'd3) begin
      errors++;
      $display("[TB] FAIL redir_count got %0d want 3", FetchCount);
    end
  endtask

  task automatic test_fault;
    Redirect = 1'b1; RedirectPC = 16'h0005;
    @(negedge Clock);
    Redirect = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      checks++;
      if ({AddrFault, MemRdEn, InstrValid} !== 3'b100) begin
        errors++;
        $display("[TB] FAIL odd_fault cyc %0d got %b want 100", i, {AddrFault, MemRdEn, InstrValid});
      end
    end
    Redirect = 1'b1; RedirectPC = 16'h0010;
    @(negedge Clock);
    Redirect = 1'b0;
    checks++;
    if (AddrFault !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fault_clear got %b want 0", AddrFault);
    end
    pushExpect(16'h0010);
    @(negedge Clock);
    checks++;
    if ({MemRdEn, MemAddr} !== {1'b1, 16'h0010}) begin
      errors++;
      $display("[TB] FAIL fault_resume got %b/%h want 1/0010", MemRdEn, MemAddr);
    end
    waitValid("fault_resume");
    exp = sb.pop_front();
    checks++;
    if ({InstrPC, Instruction} !== exp) begin
      errors++;
      $display("[TB] FAIL resume_instr got %h/%h want %h/%h", InstrPC, Instruction, exp[31:16], exp[15:0]);
    end
    @(negedge Clock);
    checks++;
    if (FetchCount !== 16'd4) begin
      errors++;
      $display("[TB] FAIL resume_count got %0d want 4", FetchCount);
    end
  endtask

  task automatic test_boundary;
    Redirect = 1'b1; RedirectPC = 16'h007C;
    @(negedge Clock);
    Redirect = 1'b0;
    pushExpect(16'h007C);
    pushExpect(16'h007E);
    for (int k = 0; k < 2; k++) begin
      waitValid("boundary");
      exp = sb.pop_front();
      checks++;
      if ({InstrPC, Instruction} !== exp) begin
        errors++;
        $display("[TB] FAIL boundary_instr %0d got %h/%h want %h/%h", k, InstrPC, Instruction, exp[31:16], exp[15:0]);
      end
      @(negedge Clock);
    end
    checks++;
    if (FetchCount !== 16'd6) begin
      errors++;
      $display("[TB] FAIL boundary_count got %0d want 6", FetchCount);
    end
    @(negedge Clock);
    checks++;
    if ({AddrFault, MemRdEn, MemAddr} !== {2'b10, 16'h0080}) begin
      errors++;
      $display("[TB] FAIL overrun_fault got %b/%b/%h want 1/0/0080", AddrFault, MemRdEn, MemAddr);
    end
  endtask

  task automatic test_redirect_accept;
    InstrReady = 1'b0;
    Redirect = 1'b1; RedirectPC = 16'h0020;
    @(negedge Clock);
    Redirect = 1'b0;
    pushExpect(16'h0020);
    waitValid("redir_accept");
    exp = sb.pop_front();
    checks++;
    if ({InstrPC, Instruction} !== exp) begin
      errors++;
      $display("[TB] FAIL ra_instr got %h/%h want %h/%h", InstrPC, Instruction, exp[31:16], exp[15:0]);
    end
    InstrReady = 1'b1; Redirect = 1'b1; RedirectPC = 16'h0030;
    @(negedge Clock);
    Redirect = 1'b0;
    checks++;
    if ({InstrValid, FetchCount, MemAddr} !== {1'b0, 16'd7, 16'h0030}) begin
      errors++;
      $display("[TB] FAIL ra_both got %b/%0d/%h want 0/7/0030", InstrValid, FetchCount, MemAddr);
    end
    pushExpect(16'h0030);
    @(negedge Clock);
    checks++;
    if ({MemRdEn, MemAddr} !== {1'b1, 16'h0030}) begin
      errors++;
      $display("[TB] FAIL ra_read got %b/%h want 1/0030", MemRdEn, MemAddr);
    end
    waitValid("ra_next");
    exp = sb.pop_front();
    checks++;
    if ({InstrPC, Instruction} !== exp) begin
      errors++;
      $display("[TB] FAIL ra_next_instr got %h/%h want %h/%h", InstrPC, Instruction, exp[31:16], exp[15:0]);
    end
    @(negedge Clock);
  endtask

  task automatic test_reset_in_done;
    repeat (3) @(negedge Clock);
    checks++;
    if ({MemRdEn, InstrValid, FetchCount} !== {2'b00, 16'd8}) begin
      errors++;
      $display("[TB] FAIL pre_reset got %b/%b/%0d want 0/0/8", MemRdEn, InstrValid, FetchCount);
    end
    ResetN = 1'b0; Redirect = 1'b1; RedirectPC = 16'h0050;
    @(negedge Clock);
    ResetN = 1'b1; Redirect = 1'b0;
    checks++;
    if ({InstrValid, AddrFault, MemRdEn, FetchCount, Instruction, InstrPC, MemAddr} !== {3'b000, 64'h0}) begin
      errors++;
      $display("[TB] FAIL done_reset got %b/%b/%b/%h/%h/%h/%h want all 0", InstrValid, AddrFault, MemRdEn, FetchCount, Instruction, InstrPC, MemAddr);
    end
    pushExpect(16'h0000);
    @(negedge Clock);
    checks++;
    if ({MemRdEn, MemAddr} !== {1'b1, 16'h0000}) begin
      errors++;
      $display("[TB] FAIL post_reset_addr got %b/%h want 1/0000", MemRdEn, MemAddr);
    end
    waitValid("post_reset");
    exp = sb.pop_front();
    checks++;
    if ({InstrPC, Instruction} !== exp) begin
      errors++;
      $display("[TB] FAIL post_reset_instr got %h/%h want %h/%h", InstrPC, Instruction, exp[31:16], exp[15:0]);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h12;
    mem[1] = 8'h34;
    test_reset();
    test_first_fetch();
    test_stall();
    test_redirect_lo();
    test_fault();
    test_boundary();
    test_redirect_accept();
    test_reset_in_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller for the byte-wide (8-bit) instruction store.
- Sequences two byte reads per 16-bit instruction: big-endian, high byte at PC, low byte at PC+1.
- Holds the assembled instruction for decode under a valid/ready handshake and owns the PC: increment, redirect on branch/jump, and address-fault detection.
- Sits between the instruction memory and the decode/control stage.

Parameters:
- ADDR_W, 16, width of PC and byte address.
- MEM_DEPTH, 128, number of bytes in instruction memory; legal PC range is 0..MEM_DEPTH-2.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- Clock  input  1  rising-edge clock.
- ResetN  input  1  synchronous, active-low reset.
- Enable  input  1  permits starting a new fetch; does not abort a fetch in flight.
- MemAddr  output  ADDR_W  byte address to instruction memory.
- MemRdEn  output  1  read strobe; memory returns MemRdData on the cycle after.
- MemRdData  input  8  byte read data, 1-cycle synchronous latency.
- Redirect  input  1  load RedirectPC and flush.
- RedirectPC  input  ADDR_W  new PC on Redirect.
- Instruction  output  16  assembled instruction {byte[PC], byte[PC+1]}.
- InstrPC  output  ADDR_W  PC of Instruction.
- InstrValid  output  1  Instruction/InstrPC valid.
- InstrReady  input  1  decode accepts when InstrValid&InstrReady.
- AddrFault  output  1  PC odd or > MEM_DEPTH-2; fetching stopped.
- FetchCount  output  16  count of accepted instructions, wraps at 16'hFFFF->0.

Behaviour:
- Reset (ResetN=0 at posedge) sets state=IDLE, PC=RESET_PC, Instruction=0, InstrPC=0, InstrValid=0, AddrFault=0, FetchCount=0. Reset mid-fetch discards all in-flight data.
- MemRdEn and MemAddr are decoded from state and PC. MemRdEn=1 only in HI and LO; MemAddr=PC in HI, PC+1 in LO, PC otherwise.
- "legal" means PC[0]==0 and PC<=MEM_DEPTH-2.
- IDLE: if Enable&legal -> HI; if Enable&!legal -> FAULT; else stay.
- HI: issue read of PC -> LO.
- LO: issue read of PC+1; capture MemRdData into hi byte -> DONE.
- DONE: Instruction<={hi,MemRdData}, InstrPC<=PC, InstrValid<=1 -> WAIT.
- WAIT: Instruction/InstrPC held stable while InstrValid=1. On InstrReady: InstrValid<=0, PC<=PC+2 (mod 2^ADDR_W), FetchCount++, -> IDLE.
- FAULT: AddrFault=1, no reads, InstrValid=0; leaves only on Redirect or reset.
- Throughput: 5 cycles per instruction with InstrReady held high.
- Latency: from IDLE with Enable=1, InstrValid rises 4 cycles later.
- Redirect has priority in every state:
  - Next cycle: PC<=RedirectPC, InstrValid<=0, AddrFault<=0, state<=IDLE, pending hi byte discarded.
  - Legality of RedirectPC is checked in IDLE, not at redirect.
- Redirect and InstrReady in the same WAIT cycle: the instruction counts as accepted (FetchCount++), but PC takes RedirectPC, not PC+2.
- Enable low has no effect outside IDLE.
- Reset has priority over Redirect.

Test Plan:
- Mem[0]=8'h12, Mem[1]=8'h34; release reset with Enable=1, InstrReady=1 -> MemAddr 0 then 1 on cycles 1,2; InstrValid high on cycle 4 with Instruction=16'h1234, InstrPC=0; FetchCount=1; next fetch at PC=2.
- InstrReady=0 for 10 cycles after InstrValid -> Instruction/InstrPC stable, MemRdEn=0, FetchCount unchanged; raise InstrReady -> single accept, PC advances by 2.
- Redirect=1, RedirectPC=16'h0040 in LO state -> InstrValid stays 0, next read address 16'h0040, Instruction from Mem[0x40],Mem[0x41].
- RedirectPC=16'h0005 (odd) -> IDLE->FAULT, AddrFault=1, no MemRdEn; Redirect to 16'h0010 clears AddrFault and fetch resumes.
- Sequential fetch to PC=16'h007E with MEM_DEPTH=128 -> succeeds. Next PC=16'h0080 -> AddrFault=1.
- Simultaneous Redirect and InstrReady in WAIT -> FetchCount increments, PC=RedirectPC. ResetN=0 during DONE -> all outputs return to reset values next cycle.
